fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard control for the execute stage.
- Tracks destination-register info for instructions in the EX and MEM slots.
- Compares ID-stage sources against those slots and produces registered 2-bit operand-select codes for the EX-stage 4:1 operand muxes.
- Detects load-use hazards and issues a one-cycle stall/bubble.

Parameters:
REG_AW, 5, register address width (32 architectural registers; register 0 hardwired zero)
STALL_CNT_W, 32, width of stall counter (optional feature only)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  REG_AW  ID source register A
id_rs2  in  REG_AW  ID source register B
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_AW  ID destination register
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
freeze  in  1  global pipeline hold (memory wait); all state held
flush  in  1  taken branch resolved in EX; squash instruction entering EX
stall_if_id  out  1  hold PC and IF/ID register (combinational)
ex_bubble  out  1  registered: EX slot holds an injected bubble
ex_fwd_a_sel  out  2  registered select for EX operand-A mux
ex_fwd_b_sel  out  2  registered select for EX operand-B mux

Behaviour:
Select encoding is fixed and matches the operand-mux input order:
- 00 = register-file value
- 01 = EX/MEM ALU result
- 10 = MEM/WB ALU result
- 11 = MEM/WB load data

Internal state:
- Two slots, EXS and MEMS, each holding {valid, rd, reg_write, mem_read}.
- "Writer" means valid & reg_write & rd != 0.

Hazard and select logic (combinational, per source X in {rs1, rs2}, only when id_use_X and X != 0):
- load_use = id_valid & EXS writer & EXS.mem_read & rd match on any used source.
- stall_if_id = load_use & ~flush. Flush wins: the stalled instruction is being squashed anyway.
- next_sel_X:
  - EXS writer, rd==X, not load → 01 (higher priority).
  - Else MEMS writer, rd==X → 10 if MEMS not load, 11 if load.
  - Else 00.
- WB-stage distance needs no forwarding; the register file bypasses internally (outside this block).

Clocked update on rising clk when freeze=0:
- MEMS <= EXS.
- If flush or stall_if_id or ~id_valid:
  - EXS.valid <= 0
  - ex_bubble <= 1
  - ex_fwd_a_sel and ex_fwd_b_sel <= 00
- Else:
  - EXS <= {1, id_rd, id_reg_write, id_mem_read}
  - ex_bubble <= 0
  - sels <= next_sel
- freeze=1: every register holds. stall_if_id still reflects the current compare.

Reset (asynchronous, rst_n=0):
- EXS.valid = MEMS.valid = 0.
- ex_bubble = 1, sels = 00.
- Reset may assert mid-stall; on release the pipeline starts empty with no stall.

Latency: selects are valid at the first EX cycle of the instruction, one clock after ID.

Boundary cases:
- A load-use stall lasts exactly one cycle: after the bubble, the load sits in MEMS and the consumer gets 11.
- Both sources match different slots: each is resolved independently.
- Both sources hit the same register: same code on A and B.
- Destination register 0 is never forwarded, even when reg_write=1.

Optional Feature:
Macro FWD_HAZARD_STATS_EN.
- Defined:
  - Add output stall_count [STALL_CNT_W-1:0].
  - It increments once per non-frozen cycle with stall_if_id=1 and saturates at all-ones.
  - Reset to 0.
- Undefined: port and counter absent; no other behaviour changes.

Decomposition:
- Shared package: fwd_sel_t encoding constants (FWD_RF=00, FWD_EXMEM_ALU=01, FWD_MEMWB_ALU=10, FWD_MEMWB_LD=11), REG_AW default, and the slot struct {valid, rd, reg_write, mem_read}.
- One natural sub-module: fwd_src_cmp. Instantiate it twice (rs1, rs2); it takes one source plus both slots and returns next_sel and the per-source load-use hit.

Test Plan:
- ADD x3 then SUB using x3 as rs1 → ex_fwd_a_sel=01 in SUB's EX cycle, no stall.
- ADD x3, unrelated instruction, then OR using x3 as rs2 → ex_fwd_b_sel=10.
- LW x5 then ADD using x5 as rs1:
  - stall_if_id=1 for exactly one cycle, ex_bubble=1 the next cycle.
  - ADD then enters EX with ex_fwd_a_sel=11.
  - With FWD_HAZARD_STATS_EN defined, stall_count=1.
- LW x5 followed by a consumer of x5 while flush=1 in the same cycle → stall_if_id=0, bubble injected, sels=00.
- Writer with rd=x0 followed by a consumer of x0 → sels=00. Also: ADD x7 in EXS and LW x7 in MEMS → 01 chosen over 11.
- freeze=1 for 3 cycles during a forwarding pair → slots and sels hold. Then assert rst_n=0 mid-stall → ex_bubble=1, sels=00, stall_if_id=0 on release.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for execute-stage forwarding/hazard control: select codes, slot record, writer test.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package fwd_hazard_ctrl_pkg;

  // Default register address width (32 architectural registers, x0 hardwired zero)
  localparam int REG_AW_DEF = 5;

  // Operand-mux select codes; order matches the EX-stage 4:1 mux inputs
  typedef enum logic [1:0] {
    FWD_RF        = 2'b00,
    FWD_EXMEM_ALU = 2'b01,
    FWD_MEMWB_ALU = 2'b10,
    FWD_MEMWB_LD  = 2'b11
  } fwd_sel_t;

  // Destination-register info carried by an instruction in a pipeline slot
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } slot_t;

  // A slot produces a forwardable value only if it is real, writes, and targets a non-zero register
  function automatic logic is_writer(slot_t s);
    return s.valid & s.reg_write & (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_src_cmp.sv
// Per-source comparator: resolves one ID source against the EX and MEM slots.
// Latency: purely combinational.
// Backpressure: none; reports a load-use hit so the parent can stall.
module fwd_src_cmp
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              use_src,
  input  logic [REG_AW-1:0] src,
  input  slot_t             exs,
  input  slot_t             mems,
  output logic [1:0]        next_sel,
  output logic              lu_hit
);

  logic active;
  logic ex_hit;
  logic mem_hit;

  // Match the source against both slots; the younger EX slot has priority over MEM
  always_comb begin
    active   = use_src & (src != '0);
    ex_hit   = active & is_writer(exs) & (exs.rd == src);
    mem_hit  = active & is_writer(mems) & (mems.rd == src);
    lu_hit   = ex_hit & exs.mem_read;
    next_sel = FWD_RF;
    if (ex_hit && !exs.mem_read) begin
      next_sel = FWD_EXMEM_ALU;
    end else if (mem_hit) begin
      next_sel = mems.mem_read ? FWD_MEMWB_LD : FWD_MEMWB_ALU;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Execute-stage forwarding selects and load-use hazard control (optional stall counter: FWD_HAZARD_STATS_EN).
// Latency: selects/bubble registered, valid in the instruction's first EX cycle (one clock after ID); stall_if_id combinational.
// Backpressure: freeze holds all state; a load-use hit stalls IF/ID for exactly one cycle and injects a bubble.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
`ifdef FWD_HAZARD_STATS_EN
  , parameter int STALL_CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              freeze,
  input  logic              flush,
  output logic              stall_if_id,
  output logic              ex_bubble,
  output logic [1:0]        ex_fwd_a_sel,
  output logic [1:0]        ex_fwd_b_sel
`ifdef FWD_HAZARD_STATS_EN
  , output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  slot_t      exs;
  slot_t      mems;
  logic [1:0] next_sel_a;
  logic [1:0] next_sel_b;
  logic       lu_a;
  logic       lu_b;
  logic       load_use;
  logic       insert_bubble;

  fwd_src_cmp #(.REG_AW(REG_AW)) u_cmp_rs1 (
    .use_src  (id_use_rs1),
    .src      (id_rs1),
    .exs      (exs),
    .mems     (mems),
    .next_sel (next_sel_a),
    .lu_hit   (lu_a)
  );

  fwd_src_cmp #(.REG_AW(REG_AW)) u_cmp_rs2 (
    .use_src  (id_use_rs2),
    .src      (id_rs2),
    .exs      (exs),
    .mems     (mems),
    .next_sel (next_sel_b),
    .lu_hit   (lu_b)
  );

  // Load-use stall; a flush squashes the stalled instruction, so it overrides the stall
  always_comb begin
    load_use      = id_valid & (lu_a | lu_b);
    stall_if_id   = load_use & ~flush;
    insert_bubble = flush | stall_if_id | ~id_valid;
  end

  // Advance the slots and register the EX-stage selects; freeze holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exs          <= '0;
      mems         <= '0;
      ex_bubble    <= 1'b1;
      ex_fwd_a_sel <= FWD_RF;
      ex_fwd_b_sel <= FWD_RF;
    end else if (!freeze) begin
      mems <= exs;
      if (insert_bubble) begin
        exs.valid    <= 1'b0;
        ex_bubble    <= 1'b1;
        ex_fwd_a_sel <= FWD_RF;
        ex_fwd_b_sel <= FWD_RF;
      end else begin
        exs.valid     <= 1'b1;
        exs.rd        <= id_rd;
        exs.reg_write <= id_reg_write;
        exs.mem_read  <= id_mem_read;
        ex_bubble     <= 1'b0;
        ex_fwd_a_sel  <= next_sel_a;
        ex_fwd_b_sel  <= next_sel_b;
      end
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  // Count non-frozen stall cycles, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (!freeze && stall_if_id && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule
